// File: rtl/demorgan_sweeper.sv
// ---------------------------------------------------------------------------
// demorgan_sweeper
// Self-checking stimulus/check stage for a two-input De Morgan gate block.
// It steps {a,b} through 00, 01, 10, 11. Each combination is held for SETTLE
// WAIT cycles plus one CHECK cycle. At the closing edge of CHECK it compares
// the gate's OR / NOR outputs against the expected values.
//
// Parameters
//   SETTLE       cycles a/b are held before the gate outputs are sampled (1..15)
//   ERRW         width of o_err_count (>= 3)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      begin a sweep; only looked at in IDLE
//   i_or_in      gate output A+B
//   i_nor_in     gate output ~(A+B)
//   o_a, o_b     registered stimulus to the gate
//   o_busy       high in WAIT and CHECK
//   o_done       one-cycle pulse when a sweep completes (the FIN cycle)
//   o_pass       1 if the last completed sweep had no mismatches
//   o_err_count  number of mismatching combinations in the last sweep
//   o_err_vec    bit i set if combination i = {a,b} mismatched
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | a=b=0, waiting for i_start
// WAIT   | a/b held, settle counter running down to 0
// CHECK  | single cycle, gate outputs sampled at its closing edge
// FIN    | done pulse; pass/err results valid, then back to IDLE
// ---------------------------------------------------------------------------
module demorgan_sweeper #(
   parameter int SETTLE = 1,
   parameter int ERRW   = 3
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_or_in,
   input  logic            i_nor_in,
   output logic            o_a,
   output logic            o_b,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [ERRW-1:0] o_err_count,
   output logic [3:0]      o_err_vec
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // Counter loads SETTLE-1 so that WAIT lasts exactly SETTLE cycles.
   localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

   state_t          r_state;
   logic [1:0]      r_idx;
   logic [3:0]      r_cnt;

   logic            w_exp_or;
   logic            w_exp_nor;
   logic            w_mismatch;
   logic [ERRW-1:0] w_err_next;
   logic [3:0]      w_vec_next;
   logic [1:0]      w_idx_next;

   // Expected values come from the registered stimulus actually on the gate.
   assign w_exp_or   = o_a | o_b;
   assign w_exp_nor  = ~w_exp_or;
   assign w_mismatch = (i_or_in != w_exp_or) || (i_nor_in != w_exp_nor);
   assign w_err_next = o_err_count + {{(ERRW-1){1'b0}}, w_mismatch};
   assign w_vec_next = o_err_vec | ({3'b000, w_mismatch} << r_idx);
   assign w_idx_next = r_idx + 2'd1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= 2'd0;
         r_cnt       <= 4'd0;
         o_a         <= 1'b0;
         o_b         <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_pass      <= 1'b0;
         o_err_count <= '0;
         o_err_vec   <= 4'd0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               o_a    <= 1'b0;
               o_b    <= 1'b0;
               o_busy <= 1'b0;
               if (i_start) begin
                  r_state     <= ST_WAIT;
                  r_idx       <= 2'd0;
                  r_cnt       <= LP_RELOAD;
                  o_busy      <= 1'b1;
                  o_pass      <= 1'b0;
                  o_err_count <= '0;
                  o_err_vec   <= 4'd0;
               end
            end

            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end

            ST_CHECK: begin
               o_err_count <= w_err_next;
               o_err_vec   <= w_vec_next;
               if (r_idx == 2'd3) begin
                  // pass must include the mismatch of this last combination.
                  r_state <= ST_FIN;
                  o_a     <= 1'b0;
                  o_b     <= 1'b0;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  o_pass  <= (w_err_next == '0);
               end else begin
                  r_state <= ST_WAIT;
                  r_idx   <= w_idx_next;
                  r_cnt   <= LP_RELOAD;
                  o_a     <= w_idx_next[1];
                  o_b     <= w_idx_next[0];
               end
            end

            ST_FIN: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/demorgan_sweeper.md
# demorgan_sweeper

Synthesizable stimulus-and-check stage for the two-input De Morgan gate blocks. It drives A and B through all four input combinations in order. It samples the gate's A+B and ~(A+B) outputs and compares them against expected values. It reports per-combination mismatches, an error count and pass/fail. It sits directly upstream and downstream of a demorgan gate instance, replacing the hand-written truth-table bench with self-checking hardware.

## Interface
- SETTLE, 1: cycles A/B are held before sampling; legal range 1..15.
- ERRW, 3: width of err_count; must be ≥3.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- or_in  in  1  gate output A+B.
- nor_in  in  1  gate output ~(A+B).
- a  out  1  stimulus A to gate (registered).
- b  out  1  stimulus B to gate (registered).
- busy  out  1  high in WAIT and CHECK.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  1 if last completed sweep had zero mismatches.
- err_count  out  ERRW  mismatching combinations in last sweep (0..4).
- err_vec  out  4  bit i set if combination i = {a,b} mismatched.

## Operation
- States: IDLE, WAIT, CHECK, FIN. 2-bit index idx selects combination; a = idx[1], b = idx[0].
- IDLE: a=b=0, busy=0. On start=1, go to WAIT. Set idx=0 and load the wait counter with SETTLE-1. Clear err_count and err_vec. pass is cleared to 0.
- WAIT: hold a/b. Decrement the counter. When the counter is 0, go to CHECK.
- CHECK: one cycle. At its closing edge:
  - Expected values: exp_or = a|b, exp_nor = ~(a|b).
  - Mismatch if or_in≠exp_or or nor_in≠exp_nor.
  - On mismatch, set err_vec[idx] and increment err_count.
  - If idx=3, go to FIN. Otherwise idx+1, reload the counter, and go to WAIT; a/b update on the same edge.
- FIN: done=1 for exactly one cycle. pass=(err_count==0), registered on entry to FIN. Then go to IDLE. a=b=0 from FIN onward.
- start is ignored in WAIT, CHECK and FIN. No queuing.
- err_count, err_vec and pass hold their values until the next accepted start or reset.
- Asynchronous reset at any time, including mid-sweep: immediately state=IDLE, idx=0, a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_vec=0. No partial results are retained.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_vec=0.
- start accepted at edge k: a/b=00 and busy=1 from edge k.
- Each combination occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in CHECK. a/b are stable across the whole window.
- or_in/nor_in are sampled only at the closing edge of CHECK. The gate may be combinational or have up to SETTLE cycles of latency.
- FIN is entered at edge k+4·(SETTLE+1). done, pass and final err_count/err_vec are valid from that edge for one cycle, then held (except done).
- If start is held continuously: FIN → IDLE → accepted. done pulses are 4·(SETTLE+1)+2 cycles apart.

## Test plan
- Reset: assert rst_n=0 mid-run. Response: all outputs at reset values within the same cycle, with no clock edge required.
- Correct gate with SETTLE=1: start pulse at edge k. Response: a/b = 00,01,10,11, each held 2 cycles. done high after edge k+8 for 1 cycle. pass=1, err_count=0, err_vec=0000.
- Wrong gate (or_in=a&b, nor_in=~(a&b)): one sweep. Response: err_vec=0110, err_count=2, pass=0.
- nor_in stuck at 0 with a correct or_in: response err_vec=0001, err_count=1, pass=0. Then a correct gate with a new start: err_vec=0000, pass=1, with results cleared at start.
- start pulsed during WAIT/CHECK: ignored, single done. start held high: done pulses 10 cycles apart (SETTLE=1).
- SETTLE=3, gate with 2-cycle registered latency: pass=1, done at k+16. With SETTLE=1, the same gate gives pass=0.
